// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: 2-way set-associative, write-back L2 cache with LRU
// replacement between a block-granular L1 port and a block-wide memory port.
// Tag/data/valid/dirty/LRU state lives in flops. Every output is registered.
module l2_cache_ctrl #(
  parameter int SETS   = 8,
  parameter int IDXLEN = 3,
  parameter int TAGLEN = 25
) (
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [29:0]              addr,
  input  logic [127:0]             wdata,
  output logic [127:0]             rdata,
  output logic                     ready,
  output logic                     stall,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAGLEN+IDXLEN-1:0] mem_addr,
  output logic [127:0]             mem_wdata,
  input  logic [127:0]             mem_rdata,
  input  logic                     mem_ready
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COMPARE   = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_ALLOCATE  = 3'd3;
  localparam logic [2:0] S_FILLW     = 3'd4;
  localparam logic [2:0] S_RESPOND   = 3'd5;

  logic [2:0]        state;
  logic [2:0]        next_state;

  // Per-set line state: one bit per way for valid/dirty, one LRU bit per set
  // naming the way to evict next.
  logic [1:0]        valid [SETS];
  logic [1:0]        dirty [SETS];
  logic [SETS-1:0]   lru;
  logic [TAGLEN-1:0] tag_arr  [SETS][2];
  logic [127:0]      data_arr [SETS][2];

  // Request latched in IDLE so L1 may change its inputs afterwards.
  logic [IDXLEN-1:0] req_idx;
  logic [TAGLEN-1:0] req_tag;
  logic              req_read;
  logic [127:0]      req_wdata;
  logic              victim;

  logic              hit0;
  logic              hit1;
  logic              hit;
  logic              hit_way;
  logic              victim_sel;
  logic              victim_dirty;

  // Word-offset bits do not participate in a block-granular cache.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Tag lookup and victim choice for the latched request.
  always_comb begin
    hit0         = valid[req_idx][0] && (tag_arr[req_idx][0] == req_tag);
    hit1         = valid[req_idx][1] && (tag_arr[req_idx][1] == req_tag);
    hit          = hit0 || hit1;
    hit_way      = !hit0;
    if (!valid[req_idx][0])      victim_sel = 1'b0;
    else if (!valid[req_idx][1]) victim_sel = 1'b1;
    else                         victim_sel = lru[req_idx];
    victim_dirty = valid[req_idx][victim_sel] && dirty[req_idx][victim_sel];
  end

  // Next-state logic of the controller FSM.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:      if (read || write) next_state = S_COMPARE;
      S_COMPARE: begin
        if (hit)               next_state = S_RESPOND;
        else if (victim_dirty) next_state = S_WRITEBACK;
        else if (req_read)     next_state = S_ALLOCATE;
        else                   next_state = S_FILLW;
      end
      S_WRITEBACK: if (mem_ready) next_state = req_read ? S_ALLOCATE : S_FILLW;
      S_ALLOCATE:  if (mem_ready) next_state = S_RESPOND;
      S_FILLW:     next_state = S_RESPOND;
      S_RESPOND:   next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // State, registered outputs, request latch and line bookkeeping.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= S_IDLE;
      rdata     <= '0;
      ready     <= 1'b0;
      stall     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lru       <= '0;
      req_idx   <= '0;
      req_tag   <= '0;
      req_read  <= 1'b0;
      req_wdata <= '0;
      victim    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= 2'b00;
        dirty[s] <= 2'b00;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= next_state;
      ready     <= (next_state == S_RESPOND);
      stall     <= (next_state == S_WRITEBACK) || (next_state == S_ALLOCATE);
      mem_read  <= (next_state == S_ALLOCATE);
      mem_write <= (next_state == S_WRITEBACK);
      case (state)
        S_IDLE: begin
          if (read || write) begin
            req_idx   <= addr[IDXLEN+1:2];
            req_tag   <= addr[29:IDXLEN+2];
            req_read  <= read;
            req_wdata <= wdata;
          end
        end
        S_COMPARE: begin
          victim <= victim_sel;
          if (hit) begin
            lru[req_idx] <= ~hit_way;
            if (req_read) rdata <= data_arr[req_idx][hit_way];
            else          dirty[req_idx][hit_way] <= 1'b1;
          end else if (victim_dirty) begin
            mem_addr  <= {tag_arr[req_idx][victim_sel], req_idx};
            mem_wdata <= data_arr[req_idx][victim_sel];
          end else if (req_read) begin
            mem_addr <= {req_tag, req_idx};
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            dirty[req_idx][victim] <= 1'b0;
            if (req_read) mem_addr <= {req_tag, req_idx};
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            valid[req_idx][victim] <= 1'b1;
            dirty[req_idx][victim] <= 1'b0;
            lru[req_idx]           <= ~victim;
            rdata                  <= mem_rdata;
          end
        end
        S_FILLW: begin
          valid[req_idx][victim] <= 1'b1;
          dirty[req_idx][victim] <= 1'b1;
          lru[req_idx]           <= ~victim;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays: written on write hit, memory fill or full-block write fill.
  // NOTE: these arrays have no reset; valid bits gate every use of their contents.
  always_ff @(posedge clk) begin
    if (state == S_COMPARE && hit && !req_read) begin
      data_arr[req_idx][hit_way] <= req_wdata;
    end else if (state == S_ALLOCATE && mem_ready) begin
      data_arr[req_idx][victim] <= mem_rdata;
      tag_arr[req_idx][victim]  <= req_tag;
    end else if (state == S_FILLW) begin
      data_arr[req_idx][victim] <= req_wdata;
      tag_arr[req_idx][victim]  <= req_tag;
    end
  end

endmodule

// File: doc/l2_cache_ctrl.md
Name: l2_cache_ctrl

Overview:
- Second-level cache between the L1 data cache and main memory.
- Accepts block-granular (128-bit) read/fill and write-back requests from L1 through its stall/ready handshake.
- 2-way set-associative, write-back, LRU replacement; misses go to a block-wide memory port.
- Cache arrays are flops; no SRAM macros.

Parameters:
- SETS, 8, number of sets (power of 2).
- IDXLEN, 3, log2(SETS).
- TAGLEN, 25, 28 - IDXLEN.

Ports:
- clk  input  1  system clock
- proc_reset  input  1  synchronous active-high reset
- read  input  1  L1 block read request, held until ready
- write  input  1  L1 block write-back request, held until ready
- addr  input  30  L1 word address; block address = addr[29:2]
- wdata  input  128  write-back block
- rdata  output  128  read block, valid while ready=1
- ready  output  1  one-cycle completion pulse
- stall  output  1  high while a memory transaction is in flight
- mem_read  output  1  memory read request, held until mem_ready
- mem_write  output  1  memory write request, held until mem_ready
- mem_addr  output  28  memory block address
- mem_wdata  output  128  victim block
- mem_rdata  input  128  fill block, valid when mem_ready=1
- mem_ready  input  1  one-cycle memory completion pulse

Behaviour:
- Clock and reset: one clock clk. proc_reset is synchronous and active-high.
- Address split: index = addr[IDXLEN+1:2]; tag = addr[29:IDXLEN+2]; addr[1:0] ignored.
- All outputs are registered.
- Reset values:
  - state IDLE.
  - valid, dirty and LRU cleared in every set.
  - rdata, ready, stall, mem_read, mem_write, mem_addr and mem_wdata all 0.
- Reset mid-transaction: abandons the transaction at that edge with no flush. Dirty data is lost (intended).
- Request priority: read=write=1 is treated as read, and write is ignored.
- FSM:
  - IDLE: read|write sampled high -> latch index/tag/op/wdata -> COMPARE. Otherwise stay.
  - COMPARE, hit: read returns the way's block; write overwrites the block and sets dirty. Update LRU to the other way -> RESPOND.
  - COMPARE, miss: choose victim = first invalid way (way0 first), else the LRU way. Victim valid&dirty -> WRITEBACK. Otherwise, read -> ALLOCATE; write -> FILLW.
  - WRITEBACK: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim block. On mem_ready, drop mem_write and clear victim dirty. Then read -> ALLOCATE; write -> FILLW.
  - ALLOCATE: mem_read=1, mem_addr={tag,index}. On mem_ready, install mem_rdata into the victim (valid=1, dirty=0, tag set), capture rdata, point LRU to the other way -> RESPOND.
  - FILLW: single cycle. Install wdata into the victim (valid=1, dirty=1), update LRU -> RESPOND. No memory read, because a write carries a full block.
  - RESPOND: ready=1 for exactly this cycle; rdata holds the block (read) or its previous value (write) -> IDLE.
- stall: 1 in WRITEBACK and ALLOCATE, and 0 elsewhere, including in RESPOND.
- Latency: hit has ready 2 cycles after the request is first sampled in IDLE. A miss adds the memory wait cycles plus 1 per memory phase.
- Back-to-back requests: L1 deasserts its request the cycle after ready, so a new request may be seen by IDLE the cycle after RESPOND. An L1 write-back followed by a read of a different block is accepted back-to-back.
- mem_read and mem_write are never high together. Both drop on the edge after mem_ready.

Test Plan:
- Reset, then read addr=0x0000010 (block 0x4, set 4) with memory returning 128'hA5..A5 after 3 cycles -> mem_read with mem_addr=0x0000004; stall high in ALLOCATE; ready pulses once with rdata=128'hA5..A5. Re-read the same block -> ready 2 cycles after request, no mem_read.
- Write block 0x4 with 128'h1234 (hit) -> ready after 2 cycles, no memory traffic. Read back -> rdata=128'h1234.
- Fill both ways of set 4 (blocks 0x4, 0xC), touch 0x4, read 0x14 -> the victim is the way holding 0xC. Because 0xC is clean, there is no mem_write.
- Dirty victim: write 0xC, write 0x4, touch 0x4, read 0x14 -> mem_write with mem_addr=0xC and the 0xC data, then mem_read 0x14, then one ready pulse.
- Write miss to an empty set 2 -> no mem_read; ready after 3 cycles (IDLE, COMPARE, FILLW). A later read of that block hits.
- Assert proc_reset while in ALLOCATE -> the next cycle has mem_read=0, stall=0 and ready=0, and all lines are invalid. Re-read -> miss.
